oam_dma: RTL and testbench

//  OAM DMA engine at register FF46. A CPU write of byte XX copies 160 bytes from
//  XX00-XX9F into OAM FE00-FE9F. Sits between the MMU (register port, bus master)
//  and the PPU's OAM write port, directly upstream of the PPU.
//  dma_active tells the MMU to block CPU access outside HRAM during a transfer.

---
 rtl/oam_dma.sv | 133 +++++++++++++
 tb/tb_oam_dma.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine at FF46: copies NUM_BYTES bytes from page XX00 into OAM FE00+.
// Optional macro OAM_DMA_ECHO_MIRROR_EN folds source pages E0-FF onto C0-DF.
module oam_dma #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4,
  parameter int NUM_BYTES       = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        dma_req,
  input  logic        dma_gnt,
  output logic [15:0] src_addr,
  input  logic [7:0]  rd_data,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  localparam int SW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(NUM_BYTES - 1);
  localparam logic [DW-1:0] DCNT_INIT = DW'(START_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [7:0]    src_hi_q, src_hi_d;
  logic [7:0]    xsrc_q, xsrc_d;
  logic [7:0]    idx_q, idx_d;
  logic [SW-1:0] slot_q, slot_d;

  logic          xfer;
  logic          byte_done;
  logic          wr_hit;
  logic [7:0]    src_eff;

  // The running transfer keeps its own page copy so a restart write
  // does not redirect the bytes still being copied from the old page.
`ifdef OAM_DMA_ECHO_MIRROR_EN
  assign src_eff = (xsrc_q >= 8'hE0) ? (xsrc_q - 8'h20) : xsrc_q;
`else
  assign src_eff = xsrc_q;
`endif

  assign xfer      = (state_q == S_XFER);
  assign byte_done = xfer && dma_gnt && (slot_q == SLOT_LAST);
  assign wr_hit    = reg_wr && (reg_addr == 16'hFF46);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      dcnt_q   <= '0;
      src_hi_q <= 8'h00;
      xsrc_q   <= 8'h00;
      idx_q    <= 8'h00;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      dcnt_q   <= dcnt_d;
      src_hi_q <= src_hi_d;
      xsrc_q   <= xsrc_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    dcnt_d   = dcnt_q;
    src_hi_d = src_hi_q;
    xsrc_d   = xsrc_q;
    idx_d    = idx_q;
    slot_d   = slot_q;

    if (xfer && dma_gnt) begin
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        idx_d  = idx_q + 8'd1;
        if (idx_q == IDX_LAST) begin
          state_d = pend_q ? S_START : S_IDLE;
        end
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end

    // Start-delay expiry wins over the old transfer's progress: restart at byte 0.
    if (pend_q) begin
      if (dcnt_q == '0) begin
        pend_d  = 1'b0;
        idx_d   = 8'h00;
        slot_d  = '0;
        xsrc_d  = src_hi_q;
        state_d = S_XFER;
      end else begin
        dcnt_d = dcnt_q - DW'(1);
      end
    end

    if (wr_hit) begin
      src_hi_d = reg_wdata;
      pend_d   = 1'b1;
      dcnt_d   = DCNT_INIT;
      if (state_d == S_IDLE) begin
        state_d = S_START;
      end
    end
  end

  assign reg_rdata  = src_hi_q;
  assign dma_req    = xfer;
  assign dma_active = xfer;
  assign src_addr   = xfer ? {src_eff, idx_q} : 16'h0000;
  assign oam_we     = byte_done;
  assign oam_addr   = byte_done ? idx_q : 8'h00;
  assign oam_wdata  = byte_done ? rd_data : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: per-cycle comparison against a tick-counting transfer model
// plus directed scenarios with hand-computed expectations.
module tb_oam_dma;
  localparam int CPB = 4;
  localparam int SD  = 4;
  localparam int NB  = 160;

  logic        clk;
  logic        reset;
  logic        reg_wr;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] src_addr;
  logic [7:0]  rd_data;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  oam_dma #(.CYCLES_PER_BYTE(CPB), .START_DELAY(SD), .NUM_BYTES(NB)) dut (
    .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .dma_req(dma_req),
    .dma_gnt(dma_gnt), .src_addr(src_addr), .rd_data(rd_data),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .dma_active(dma_active)
  );

  // Source memory contents are a fixed function of the address.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  assign rd_data = mem(src_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Model: a transfer is a count of granted ticks; byte and phase follow by division.
  bit         mv = 1'b0;
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_xpage = 8'h00;
  int         m_pend = 0;
  bit         m_run = 1'b0;
  int         m_granted = 0;

  int          step_no = 0;
  int          we_cnt = 0;
  int          last_we_step = 0;
  int          last_act_step = 0;
  logic [15:0] first_src = 16'h0;
  logic [15:0] last_src = 16'h0;
  logic [7:0]  last_addr = 8'h0;
  logic        s_req, s_act, s_we;
  logic [15:0] s_src;
  logic [7:0]  s_rdata;

  function automatic logic [7:0] eff(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h step=%0d t=%0t", nm, act, exp, step_no, $time);
    end
  endtask

  task automatic clr_stats();
    step_no = 0; we_cnt = 0; last_we_step = 0; last_act_step = 0;
    first_src = 16'h0; last_src = 16'h0; last_addr = 8'h0;
  endtask

  task automatic step(input bit rst, input bit wr, input logic [15:0] a,
                      input logic [7:0] d, input bit g);
    int          bi;
    logic        e_we;
    logic [15:0] e_src;
    @(negedge clk);
    reset = rst; reg_wr = wr; reg_addr = a; reg_wdata = d; dma_gnt = g;
    #1;
    step_no++;
    if (mv) begin
      bi    = m_granted / CPB;
      e_src = m_run ? {eff(m_xpage), 8'(bi)} : 16'h0000;
      e_we  = m_run && g && ((m_granted % CPB) == CPB - 1);
      chk("reg_rdata", {8'h00, reg_rdata}, {8'h00, m_page});
      chk("dma_req", {15'h0, dma_req}, {15'h0, m_run});
      chk("dma_active", {15'h0, dma_active}, {15'h0, m_run});
      chk("src_addr", src_addr, e_src);
      chk("oam_we", {15'h0, oam_we}, {15'h0, e_we});
      chk("oam_addr", {8'h00, oam_addr}, e_we ? 16'(bi) : 16'h0000);
      chk("oam_wdata", {8'h00, oam_wdata}, e_we ? {8'h00, mem(e_src)} : 16'h0000);
    end
    s_req = dma_req; s_act = dma_active; s_we = oam_we; s_src = src_addr; s_rdata = reg_rdata;
    if (s_act === 1'b1) last_act_step = step_no;
    if (s_we === 1'b1) begin
      if (we_cnt == 0) first_src = s_src;
      we_cnt++;
      last_we_step = step_no;
      last_src = s_src;
      last_addr = oam_addr;
    end
    @(posedge clk);
    if (rst) begin
      mv = 1'b1; m_page = 8'h00; m_xpage = 8'h00; m_pend = 0; m_run = 1'b0; m_granted = 0;
    end else begin
      if (m_run && g) begin
        m_granted++;
        if (m_granted == NB * CPB) m_run = 1'b0;
      end
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_run = 1'b1; m_granted = 0; m_xpage = m_page;
        end
      end
      if (wr && a == 16'hFF46) begin
        m_page = d; m_pend = SD;
      end
    end
  endtask

  initial begin
    int low_cnt;
    bit g;
    reset = 1'b1; reg_wr = 1'b0; reg_addr = 16'h0; reg_wdata = 8'h0; dma_gnt = 1'b0;

    // T1: reset
    repeat (3) step(1, 0, 16'h0, 8'h0, 1);
    step(0, 0, 16'h0, 8'h0, 1);
    chk("t1_req", {15'h0, s_req}, 16'h0);
    chk("t1_active", {15'h0, s_act}, 16'h0);
    chk("t1_we", {15'h0, s_we}, 16'h0);
    chk("t1_src", s_src, 16'h0);
    chk("t1_rdata", {8'h0, s_rdata}, 16'h0);

    // T2: nominal transfer
    step(0, 1, 16'hFF46, 8'hC1, 1);
    clr_stats();
    for (int k = 1; k <= 660; k++) step(0, 0, 16'h0, 8'h0, 1);
    chk("t2_we_cnt", 16'(we_cnt), 16'd160);
    chk("t2_last_we", 16'(last_we_step), 16'd644);
    chk("t2_last_act", 16'(last_act_step), 16'd644);
    chk("t2_first_src", first_src, 16'hC100);
    chk("t2_last_src", last_src, 16'hC19F);
    chk("t2_last_addr", {8'h0, last_addr}, 16'd159);
    chk("t2_rdata", {8'h0, s_rdata}, 16'h00C1);

    // T3: 10-cycle grant stall inside byte 37
    step(0, 1, 16'hFF46, 8'hC1, 1);
    clr_stats();
    for (int k = 1; k <= 670; k++) begin
      g = !(k >= 154 && k <= 163);
      step(0, 0, 16'h0, 8'h0, g);
      if (!g) begin
        chk("t3_hold_src", s_src, 16'hC125);
        chk("t3_stall_we", {15'h0, s_we}, 16'h0);
        chk("t3_stall_req", {15'h0, s_req}, 16'h1);
      end
    end
    chk("t3_we_cnt", 16'(we_cnt), 16'd160);
    chk("t3_last_we", 16'(last_we_step), 16'd654);

    // T4: restart at byte 80
    step(0, 1, 16'hFF46, 8'hC1, 1);
    clr_stats();
    low_cnt = 0;
    for (int k = 1; k <= 990; k++) begin
      step(0, (k == 326), 16'hFF46, 8'hD0, 1);
      if (k >= 5 && k <= 970 && s_act !== 1'b1) low_cnt++;
      if (k == 5) chk("t4_first_src", s_src, 16'hC100);
      if (k == 328) chk("t4_old_b80", s_src, 16'hC150);
      if (k == 331) begin
        chk("t4_restart_src", s_src, 16'hD000);
        chk("t4_rdata", {8'h0, s_rdata}, 16'h00D0);
      end
    end
    chk("t4_gap", 16'(low_cnt), 16'd0);
    chk("t4_we_cnt", 16'(we_cnt), 16'd241);
    chk("t4_last_we", 16'(last_we_step), 16'd970);
    chk("t4_last_src", last_src, 16'hD09F);

    // T5: echo page
    step(0, 1, 16'hFF46, 8'hFE, 1);
    clr_stats();
    for (int k = 1; k <= 650; k++) begin
      step(0, 0, 16'h0, 8'h0, 1);
`ifdef OAM_DMA_ECHO_MIRROR_EN
      if (k == 5) chk("t5_src", s_src, 16'hDE00);
`else
      if (k == 5) chk("t5_src", s_src, 16'hFE00);
`endif
    end
    chk("t5_we_cnt", 16'(we_cnt), 16'd160);

    // T6: reset during byte 50
    step(0, 1, 16'hFF46, 8'hC1, 1);
    clr_stats();
    for (int k = 1; k <= 230; k++) begin
      step((k == 206), 0, 16'h0, 8'h0, 1);
      if (k == 206) chk("t6_pre_we_cnt", 16'(we_cnt), 16'd50);
      if (k == 207) begin
        chk("t6_we", {15'h0, s_we}, 16'h0);
        chk("t6_req", {15'h0, s_req}, 16'h0);
        chk("t6_active", {15'h0, s_act}, 16'h0);
        chk("t6_rdata", {8'h0, s_rdata}, 16'h0);
      end
    end
    chk("t6_we_cnt", 16'(we_cnt), 16'd50);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 2999) == 0),
           ($urandom_range(0, 499) == 0),
           ($urandom_range(0, 3) == 0) ? 16'hFF47 : 16'hFF46,
           8'($urandom),
           ($urandom_range(0, 9) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
